// File: rtl/ppu_pkg.sv
// Shared types, constants and helpers for the ppu fetch/decode front end.
package ppu_pkg;

  // Decoded instruction class, derived from bits [27:25]
  typedef enum logic [1:0] {
    IC_UNDEF = 2'b00,
    IC_DP    = 2'b01,
    IC_LS    = 2'b10,
    IC_BR    = 2'b11
  } instr_class_e;

  localparam logic [2:0] CLS_DP_REG = 3'b000;
  localparam logic [2:0] CLS_DP_IMM = 3'b001;
  localparam logic [2:0] CLS_LS_IMM = 3'b010;
  localparam logic [2:0] CLS_LS_REG = 3'b011;
  localparam logic [2:0] CLS_BRANCH = 3'b101;

  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_MOV = 4'b1101;
  localparam logic [3:0] ALU_MVN = 4'b1111;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_WB  = 2'b11
  } fwd_sel_e;

  typedef enum logic [1:0] {
    AM_OFFSET = 2'b00,
    AM_PRE    = 2'b01,
    AM_POST   = 2'b10
  } addr_mode_e;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  function automatic instr_class_e classify(input logic [2:0] bits);
    instr_class_e c;
    case (bits)
      CLS_DP_REG, CLS_DP_IMM: c = IC_DP;
      CLS_LS_IMM, CLS_LS_REG: c = IC_LS;
      CLS_BRANCH:             c = IC_BR;
      default:                c = IC_UNDEF;
    endcase
    return c;
  endfunction

  // nzcv = {N, Z, C, V}; NV is treated as never-execute
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v, r;
    n = nzcv[3];
    z = nzcv[2];
    c = nzcv[1];
    v = nzcv[0];
    case (cond)
      COND_EQ: r = z;
      COND_NE: r = !z;
      COND_CS: r = c;
      COND_CC: r = !c;
      COND_MI: r = n;
      COND_PL: r = !n;
      COND_VS: r = v;
      COND_VC: r = !v;
      COND_HI: r = c && !z;
      COND_LS: r = !c || z;
      COND_GE: r = (n == v);
      COND_LT: r = (n != v);
      COND_GT: r = !z && (n == v);
      COND_LE: r = z || (n != v);
      COND_AL: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] amt);
    logic [63:0] t;
    t = {v, v} >> amt;
    return t[31:0];
  endfunction

  // R15 is never forwarded: its read value is derived from the IF/ID PC
  function automatic fwd_sel_e pick_fwd(
    input logic [3:0] r,
    input logic [3:0] ex_rd,  input logic ex_we,
    input logic [3:0] mem_rd, input logic mem_we,
    input logic [3:0] wb_rd,  input logic wb_we
  );
    fwd_sel_e s;
    if (r == 4'd15)                 s = FWD_RF;
    else if (ex_we && ex_rd == r)   s = FWD_EX;
    else if (mem_we && mem_rd == r) s = FWD_MEM;
    else if (wb_we && wb_rd == r)   s = FWD_WB;
    else                            s = FWD_RF;
    return s;
  endfunction

endpackage

// File: rtl/ppu_reg_file.sv
// 16x32 register file: two read ports, one write port, write-through bypass.
// R15 is not stored-and-read here; the parent supplies its read value.
module ppu_reg_file (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  raddr_a_i,
  input  logic [3:0]  raddr_b_i,
  input  logic [31:0] r15_i,
  input  logic        we_i,
  input  logic [3:0]  waddr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_a_o,
  output logic [31:0] rdata_b_o
);

  logic [31:0] regs_q [16];

  // Register storage: cleared by synchronous reset, single write port
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Read port A: R15 override, then same-cycle write bypass, then storage
  always_comb begin
    rdata_a_o = regs_q[raddr_a_i];
    if (we_i && waddr_i == raddr_a_i) rdata_a_o = wdata_i;
    if (raddr_a_i == 4'd15) rdata_a_o = r15_i;
  end

  // Read port B: same priority as port A
  always_comb begin
    rdata_b_o = regs_q[raddr_b_i];
    if (we_i && waddr_i == raddr_b_i) rdata_b_o = wdata_i;
    if (raddr_b_i == 4'd15) rdata_b_o = r15_i;
  end

endmodule

// File: rtl/ppu_front_end.sv
// Fetch and decode front end: PC, instruction memory, IF/ID register,
// register file, decoder, operand forwarding, load-use stall, branch resolve.
module ppu_front_end
  import ppu_pkg::*;
#(
  parameter int IMEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  ex_rd,
  input  logic [3:0]  mem_rd,
  input  logic        ex_reg_write,
  input  logic        mem_reg_write,
  input  logic        ex_is_load,
  input  logic [31:0] ex_result,
  input  logic [31:0] mem_result,
  input  logic [31:0] wb_result,
  input  logic [31:0] write_data,
  input  logic [3:0]  write_reg,
  input  logic        write_enable,
  input  logic [3:0]  flags,
  output logic [31:0] current_pc,
  output logic [31:0] instruction,
  output logic [31:0] pc_plus_4,
  output logic [31:0] instruction_id,
  output logic [31:0] operand_a,
  output logic [31:0] operand_b,
  output logic [31:0] imm_out,
  output logic [3:0]  rd_id,
  output logic        reg_write_enable,
  output logic        mem_enable,
  output logic        mem_rw,
  output logic        mem_to_reg_select,
  output logic        alu_source_select,
  output logic        status_bit,
  output logic        mem_size,
  output logic [3:0]  alu_operation,
  output logic [1:0]  addressing_mode,
  output logic [1:0]  forward_sel_a,
  output logic [1:0]  forward_sel_b,
  output logic        stall_pipeline,
  output logic        flush_pipeline,
  output logic [31:0] branch_target
);

  localparam int AW = $clog2(IMEM_BYTES);

  // Byte-wide instruction memory, loaded externally
  logic [7:0] memory [IMEM_BYTES];

  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic        ifid_valid_q, ifid_valid_d;

  // ---------------- fetch ----------------
  logic [AW-1:0] fa0, fa1, fa2, fa3;

  assign fa0 = pc_q[AW-1:0];
  assign fa1 = fa0 + AW'(1);
  assign fa2 = fa0 + AW'(2);
  assign fa3 = fa0 + AW'(3);

  assign instruction = {memory[fa0], memory[fa1], memory[fa2], memory[fa3]};
  assign current_pc  = pc_q;
  assign pc_plus_4   = pc_q + 32'd4;

  // ---------------- decode ----------------
  logic [31:0]  ins;
  instr_class_e cls;
  logic         cond_ok;
  logic [31:0]  br_offset;

  assign ins       = ifid_instr_q;
  assign cls       = classify(ins[27:25]);
  assign cond_ok   = cond_pass(ins[31:28], flags);
  assign br_offset = {{6{ins[23]}}, ins[23:0], 2'b00};

  logic [3:0]  rn_addr, rb_addr;
  logic        use_rn, use_rb;
  logic        dec_rw, dec_men, dec_mrw, dec_m2r, dec_asrc, dec_s, dec_msize;
  logic [3:0]  dec_aluop, dec_rd;
  addr_mode_e  dec_am;
  logic [31:0] dec_imm;

  // Raw per-class decode, before bubble gating
  always_comb begin
    rn_addr   = ins[19:16];
    rb_addr   = ins[3:0];
    use_rn    = 1'b0;
    use_rb    = 1'b0;
    dec_rw    = 1'b0;
    dec_men   = 1'b0;
    dec_mrw   = 1'b0;
    dec_m2r   = 1'b0;
    dec_asrc  = 1'b0;
    dec_s     = 1'b0;
    dec_msize = 1'b0;
    dec_aluop = 4'd0;
    dec_am    = AM_OFFSET;
    dec_imm   = 32'd0;
    dec_rd    = 4'd0;
    case (cls)
      IC_DP: begin
        dec_aluop = ins[24:21];
        dec_s     = ins[20];
        dec_asrc  = ins[25];
        // compare/test opcodes 10xx only set flags
        dec_rw    = (ins[24:23] != 2'b10);
        dec_imm   = ror32({24'd0, ins[7:0]}, {ins[11:8], 1'b0});
        dec_rd    = ins[15:12];
        use_rn    = (ins[24:21] != ALU_MOV) && (ins[24:21] != ALU_MVN);
        use_rb    = !ins[25];
      end
      IC_LS: begin
        dec_men   = 1'b1;
        dec_mrw   = !ins[20];
        dec_msize = ins[22];
        dec_m2r   = ins[20];
        dec_rw    = ins[20];
        dec_aluop = ins[23] ? ALU_ADD : ALU_SUB;
        dec_asrc  = !ins[25];
        dec_imm   = {20'd0, ins[11:0]};
        dec_rd    = ins[15:12];
        if (!ins[24])     dec_am = AM_POST;
        else if (ins[21]) dec_am = AM_PRE;
        else              dec_am = AM_OFFSET;
        use_rn    = 1'b1;
        // stores carry Rd on operand B; loads read Rm only for register offsets
        if (!ins[20]) begin
          rb_addr = ins[15:12];
          use_rb  = 1'b1;
        end else begin
          use_rb  = ins[25];
        end
      end
      IC_BR: begin
        dec_imm = br_offset;
      end
      default: begin
      end
    endcase
  end

  // ---------------- register file and forwarding ----------------
  logic [31:0] rf_a, rf_b, r15_val;
  fwd_sel_e    fwd_a, fwd_b;

  assign r15_val = ifid_pc4_q + 32'd4;

  ppu_reg_file u_reg_file (
    .clk       (clk),
    .reset     (reset),
    .raddr_a_i (rn_addr),
    .raddr_b_i (rb_addr),
    .r15_i     (r15_val),
    .we_i      (write_enable),
    .waddr_i   (write_reg),
    .wdata_i   (write_data),
    .rdata_a_o (rf_a),
    .rdata_b_o (rf_b)
  );

  assign fwd_a = pick_fwd(rn_addr, ex_rd, ex_reg_write, mem_rd, mem_reg_write,
                          write_reg, write_enable);
  assign fwd_b = pick_fwd(rb_addr, ex_rd, ex_reg_write, mem_rd, mem_reg_write,
                          write_reg, write_enable);

  assign forward_sel_a = fwd_a;
  assign forward_sel_b = fwd_b;

  // Operand A source mux
  always_comb begin
    case (fwd_a)
      FWD_EX:  operand_a = ex_result;
      FWD_MEM: operand_a = mem_result;
      FWD_WB:  operand_a = wb_result;
      default: operand_a = rf_a;
    endcase
  end

  // Operand B source mux
  always_comb begin
    case (fwd_b)
      FWD_EX:  operand_b = ex_result;
      FWD_MEM: operand_b = mem_result;
      FWD_WB:  operand_b = wb_result;
      default: operand_b = rf_b;
    endcase
  end

  // ---------------- hazards and branch ----------------
  logic src_hit, bubble;

  assign branch_target  = ifid_pc4_q + 32'd4 + br_offset;
  assign flush_pipeline = ifid_valid_q & (cls == IC_BR) & cond_ok;
  assign src_hit        = (use_rn && ex_rd == rn_addr) || (use_rb && ex_rd == rb_addr);
  assign stall_pipeline = ifid_valid_q & ex_is_load & src_hit & ~flush_pipeline;
  assign bubble         = ~ifid_valid_q | ~cond_ok | (cls == IC_UNDEF) | stall_pipeline;

  assign imm_out = dec_imm;
  assign rd_id   = dec_rd;

  // Control outputs, forced to zero for a bubble
  always_comb begin
    reg_write_enable  = 1'b0;
    mem_enable        = 1'b0;
    mem_rw            = 1'b0;
    mem_to_reg_select = 1'b0;
    alu_source_select = 1'b0;
    status_bit        = 1'b0;
    mem_size          = 1'b0;
    alu_operation     = 4'd0;
    addressing_mode   = 2'b00;
    if (!bubble) begin
      reg_write_enable  = dec_rw;
      mem_enable        = dec_men;
      mem_rw            = dec_mrw;
      mem_to_reg_select = dec_m2r;
      alu_source_select = dec_asrc;
      status_bit        = dec_s;
      mem_size          = dec_msize;
      alu_operation     = dec_aluop;
      addressing_mode   = dec_am;
    end
  end

  // ---------------- PC and IF/ID ----------------
  // Next PC and IF/ID contents: flush beats stall beats advance
  always_comb begin
    pc_d         = pc_q + 32'd4;
    ifid_instr_d = instruction;
    ifid_pc4_d   = pc_plus_4;
    ifid_valid_d = 1'b1;
    if (flush_pipeline) begin
      pc_d         = branch_target;
      ifid_instr_d = 32'd0;
      ifid_pc4_d   = 32'd0;
      ifid_valid_d = 1'b0;
    end else if (stall_pipeline) begin
      pc_d         = pc_q;
      ifid_instr_d = ifid_instr_q;
      ifid_pc4_d   = ifid_pc4_q;
      ifid_valid_d = ifid_valid_q;
    end
  end

  // PC and IF/ID registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q         <= 32'd0;
      ifid_instr_q <= 32'd0;
      ifid_pc4_q   <= 32'd0;
      ifid_valid_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign instruction_id = ifid_instr_q;

endmodule

// File: tb/tb_ppu_front_end.sv
// Self-checking bench for ppu_front_end: directed program plus random programs,
// every cycle compared against an instruction-level reference model.
module tb_ppu_front_end;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [3:0]  ex_rd, mem_rd, write_reg, flags;
  logic        ex_reg_write, mem_reg_write, ex_is_load, write_enable;
  logic [31:0] ex_result, mem_result, wb_result, write_data;

  logic [31:0] current_pc, instruction, pc_plus_4, instruction_id;
  logic [31:0] operand_a, operand_b, imm_out, branch_target;
  logic [3:0]  rd_id, alu_operation;
  logic        reg_write_enable, mem_enable, mem_rw, mem_to_reg_select;
  logic        alu_source_select, status_bit, mem_size;
  logic [1:0]  addressing_mode, forward_sel_a, forward_sel_b;
  logic        stall_pipeline, flush_pipeline;

  ppu_front_end #(.IMEM_BYTES(256)) dut (
    .clk(clk), .reset(reset),
    .ex_rd(ex_rd), .mem_rd(mem_rd),
    .ex_reg_write(ex_reg_write), .mem_reg_write(mem_reg_write), .ex_is_load(ex_is_load),
    .ex_result(ex_result), .mem_result(mem_result), .wb_result(wb_result),
    .write_data(write_data), .write_reg(write_reg), .write_enable(write_enable),
    .flags(flags),
    .current_pc(current_pc), .instruction(instruction), .pc_plus_4(pc_plus_4),
    .instruction_id(instruction_id), .operand_a(operand_a), .operand_b(operand_b),
    .imm_out(imm_out), .rd_id(rd_id),
    .reg_write_enable(reg_write_enable), .mem_enable(mem_enable), .mem_rw(mem_rw),
    .mem_to_reg_select(mem_to_reg_select), .alu_source_select(alu_source_select),
    .status_bit(status_bit), .mem_size(mem_size),
    .alu_operation(alu_operation), .addressing_mode(addressing_mode),
    .forward_sel_a(forward_sel_a), .forward_sel_b(forward_sel_b),
    .stall_pipeline(stall_pipeline), .flush_pipeline(flush_pipeline),
    .branch_target(branch_target)
  );

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [7:0]  m_mem [256];
  logic [31:0] m_regs [16];
  logic [31:0] m_pc, m_ins, m_pc4;
  logic        m_valid;

  // expected outputs for the current cycle
  logic [31:0] e_instr, e_opa, e_opb, e_imm, e_target;
  logic [3:0]  e_rd, e_aluop;
  logic [1:0]  e_am, e_fa, e_fb;
  logic        e_rw, e_men, e_mrw, e_m2r, e_asrc, e_s, e_msize, e_stall, e_flush;
  logic        e_is_br_live;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [12:0] ctrl_vec();
    return {reg_write_enable, mem_enable, mem_rw, mem_to_reg_select, alu_source_select,
            status_bit, mem_size, alu_operation, addressing_mode};
  endfunction

  function automatic bit m_cond(input logic [3:0] c, input logic [3:0] f);
    bit base;
    case (c[3:1])
      3'd0: base = f[2];
      3'd1: base = f[1];
      3'd2: base = f[3];
      3'd3: base = f[0];
      3'd4: base = f[1] && !f[2];
      3'd5: base = (f[3] == f[0]);
      3'd6: base = !f[2] && (f[3] == f[0]);
      default: base = 1'b1;
    endcase
    if (c == 4'hF) return 1'b0;
    if (c == 4'hE) return 1'b1;
    return c[0] ? !base : base;
  endfunction

  task automatic m_operand(input logic [3:0] r, output logic [1:0] sel, output logic [31:0] val);
    if (r == 4'd15) begin sel = 2'd0; val = m_pc4 + 32'd4; end
    else if (ex_reg_write && ex_rd == r) begin sel = 2'd1; val = ex_result; end
    else if (mem_reg_write && mem_rd == r) begin sel = 2'd2; val = mem_result; end
    else if (write_enable && write_reg == r) begin sel = 2'd3; val = wb_result; end
    else begin sel = 2'd0; val = m_regs[r]; end
  endtask

  task automatic model_eval();
    logic [31:0] w, rot;
    logic [7:0]  a;
    logic [3:0]  op, rn, rb;
    logic [2:0]  cls;
    bit is_dp, is_ls, is_br, ok, uses_rn, uses_rb, live;
    int off;
    a = m_pc[7:0];
    e_instr = {m_mem[a], m_mem[8'(a + 8'd1)], m_mem[8'(a + 8'd2)], m_mem[8'(a + 8'd3)]};
    w   = m_ins;
    op  = w[24:21];
    cls = w[27:25];
    is_dp = (cls == 3'd0) || (cls == 3'd1);
    is_ls = (cls == 3'd2) || (cls == 3'd3);
    is_br = (cls == 3'd5);
    ok    = m_cond(w[31:28], flags);
    rn    = w[19:16];
    rb    = (is_ls && !w[20]) ? w[15:12] : w[3:0];
    uses_rn = (is_dp && op != 4'hD && op != 4'hF) || is_ls;
    uses_rb = (is_dp && !w[25]) || (is_ls && (!w[20] || w[25]));
    off = int'($signed(w[23:0])) * 4;
    e_target = m_pc4 + 32'd4 + 32'(off);
    e_flush  = m_valid && is_br && ok;
    e_stall  = m_valid && ex_is_load && !e_flush &&
               ((uses_rn && ex_rd == rn) || (uses_rb && ex_rd == rb));
    e_is_br_live = m_valid && is_br;
    live = m_valid && ok && (is_dp || is_ls || is_br) && !e_stall;
    e_rw    = live && ((is_dp && !(op >= 4'd8 && op <= 4'd11)) || (is_ls && w[20]));
    e_men   = live && is_ls;
    e_mrw   = live && is_ls && !w[20];
    e_m2r   = live && is_ls && w[20];
    e_asrc  = live && ((is_dp && w[25]) || (is_ls && !w[25]));
    e_s     = live && is_dp && w[20];
    e_msize = live && is_ls && w[22];
    e_aluop = !live ? 4'd0 : is_dp ? op : is_ls ? (w[23] ? 4'b0100 : 4'b0010) : 4'd0;
    e_am    = (live && is_ls) ? (!w[24] ? 2'd2 : (w[21] ? 2'd1 : 2'd0)) : 2'd0;
    rot = {24'd0, w[7:0]};
    for (int i = 0; i < 2 * int'(w[11:8]); i++) rot = {rot[0], rot[31:1]};
    e_imm = is_dp ? rot : is_ls ? {20'd0, w[11:0]} : is_br ? 32'(off) : 32'd0;
    e_rd  = (is_dp || is_ls) ? w[15:12] : 4'd0;
    m_operand(rn, e_fa, e_opa);
    m_operand(rb, e_fb, e_opb);
  endtask

  task automatic model_reset();
    m_pc = 0; m_ins = 0; m_pc4 = 0; m_valid = 0;
    for (int i = 0; i < 16; i++) m_regs[i] = 0;
  endtask

  task automatic model_step();
    if (!reset) model_reset();
    else begin
      if (write_enable) m_regs[write_reg] = write_data;
      if (e_flush) begin
        m_pc = e_target; m_ins = 0; m_pc4 = 0; m_valid = 0;
      end else if (!e_stall) begin
        m_ins = e_instr; m_pc4 = m_pc + 32'd4; m_valid = 1'b1; m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic compare_all();
    chk("current_pc", current_pc, m_pc);
    chk("pc_plus_4", pc_plus_4, m_pc + 32'd4);
    chk("instruction", instruction, e_instr);
    chk("instruction_id", instruction_id, m_ins);
    chk("operand_a", operand_a, e_opa);
    chk("operand_b", operand_b, e_opb);
    chk("forward_sel_a", 32'(forward_sel_a), 32'(e_fa));
    chk("forward_sel_b", 32'(forward_sel_b), 32'(e_fb));
    chk("imm_out", imm_out, e_imm);
    chk("rd_id", 32'(rd_id), 32'(e_rd));
    chk("controls", 32'(ctrl_vec()),
        32'({e_rw, e_men, e_mrw, e_m2r, e_asrc, e_s, e_msize, e_aluop, e_am}));
    chk("stall_pipeline", 32'(stall_pipeline), 32'(e_stall));
    chk("flush_pipeline", 32'(flush_pipeline), 32'(e_flush));
    if (e_is_br_live) chk("branch_target", branch_target, e_target);
  endtask

  // called 1 time unit after a falling edge with inputs settled
  task automatic tick();
    model_eval();
    compare_all();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic put_word(input int a, input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      m_mem[(a + k) % 256] = w[31 - 8*k -: 8];
      dut.memory[(a + k) % 256] = w[31 - 8*k -: 8];
    end
  endtask

  task automatic idle_inputs();
    ex_rd = 0; mem_rd = 0; ex_reg_write = 0; mem_reg_write = 0; ex_is_load = 0;
    ex_result = 0; mem_result = 0; wb_result = 0; write_data = 0;
    write_reg = 0; write_enable = 0; flags = 0;
  endtask

  function automatic logic [3:0] rreg();
    return ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [3:0] cond;
    int k, off;
    cond = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hE;
    k = $urandom_range(0, 9);
    if (k <= 3)
      return {cond, 2'b00, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), rreg(), rreg(),
              4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), rreg()};
    if (k <= 6)
      return {cond, 2'b01, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
              rreg(), rreg(), 8'($urandom_range(0, 255)), rreg()};
    if (k <= 8) begin
      off = $urandom_range(0, 16) - 8;
      return {cond, 3'b101, 1'($urandom_range(0, 1)), 24'(off)};
    end
    return $urandom();
  endfunction

  task automatic randomize_inputs();
    ex_rd = rreg(); mem_rd = rreg(); write_reg = rreg();
    ex_reg_write = 1'($urandom_range(0, 1));
    mem_reg_write = 1'($urandom_range(0, 1));
    ex_is_load = ($urandom_range(0, 2) == 0);
    write_enable = 1'($urandom_range(0, 1));
    ex_result = $urandom(); mem_result = $urandom();
    wb_result = $urandom(); write_data = $urandom();
    flags = 4'($urandom_range(0, 15));
    reset = ($urandom_range(0, 199) != 0);
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    for (int a = 0; a < 256; a += 4) put_word(a, 32'd0);
    put_word(0,  32'hE3A01005);  // MOV R1,#5
    put_word(4,  32'hE0812001);  // ADD R2,R1,R1
    put_word(8,  32'hEA000000);  // B   -> 16
    put_word(12, 32'hE3A02007);  // squashed
    put_word(16, 32'hE0834003);  // ADD R4,R3,R3
    put_word(20, 32'h0A000000);  // BEQ (not taken)
    put_word(24, 32'hE0856001);  // ADD R6,R5,R1
    put_word(28, 32'h0A000000);  // BEQ (taken) -> 36
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();

    #1;
    chk("reset_pc", current_pc, 32'd0);
    chk("reset_stall", 32'(stall_pipeline), 32'd0);
    chk("reset_flush", 32'(flush_pipeline), 32'd0);
    chk("reset_ctrl", 32'(ctrl_vec()), 32'd0);
    tick();

    reset = 1'b1; #1; tick();

    #1;
    chk("mov_instr_id", instruction_id, 32'hE3A01005);
    chk("mov_aluop", 32'(alu_operation), 32'hD);
    chk("mov_asrc", 32'(alu_source_select), 32'd1);
    chk("mov_imm", imm_out, 32'd5);
    chk("mov_rd", 32'(rd_id), 32'd1);
    tick();

    ex_rd = 4'd1; ex_reg_write = 1'b1; ex_result = 32'd5; #1;
    chk("add_fwd_a", 32'(forward_sel_a), 32'd1);
    chk("add_fwd_b", 32'(forward_sel_b), 32'd1);
    chk("add_opa", operand_a, 32'd5);
    chk("add_opb", operand_b, 32'd5);
    tick();

    idle_inputs(); #1;
    chk("b_pc", current_pc, 32'd12);
    chk("b_flush", 32'(flush_pipeline), 32'd1);
    chk("b_target", branch_target, 32'd16);
    tick();

    #1;
    chk("b_next_pc", current_pc, 32'd16);
    chk("b_squash_id", instruction_id, 32'd0);
    chk("b_squash_ctrl", 32'(ctrl_vec()), 32'd0);
    tick();

    ex_is_load = 1'b1; ex_rd = 4'd3; #1;
    chk("lu_stall", 32'(stall_pipeline), 32'd1);
    chk("lu_ctrl", 32'(ctrl_vec()), 32'd0);
    chk("lu_pc", current_pc, 32'd20);
    tick();

    idle_inputs(); #1;
    chk("lu_pc_held", current_pc, 32'd20);
    chk("lu_id_held", instruction_id, 32'hE0834003);
    chk("lu_release_rw", 32'(reg_write_enable), 32'd1);
    tick();

    flags = 4'b0000; #1;
    chk("beq_nz_flush", 32'(flush_pipeline), 32'd0);
    chk("beq_nz_ctrl", 32'(ctrl_vec()), 32'd0);
    tick();

    write_enable = 1'b1; write_reg = 4'd5; write_data = 32'h1234; wb_result = 32'h1234; #1;
    chk("wb_opa", operand_a, 32'h1234);
    chk("wb_fwd_a", 32'(forward_sel_a), 32'd3);
    tick();

    idle_inputs(); flags = 4'b0100; #1;
    chk("beq_z_flush", 32'(flush_pipeline), 32'd1);
    chk("beq_z_target", branch_target, 32'd36);
    tick();

    idle_inputs(); #1;
    chk("beq_z_next_pc", current_pc, 32'd36);
    chk("beq_z_squash", instruction_id, 32'd0);
    tick();

    for (int round = 0; round < 3; round++) begin
      for (int a = 0; a < 256; a += 4) put_word(a, gen_instr());
      for (int c = 0; c < 2500 && n_errors < 50; c++) begin
        randomize_inputs();
        #1;
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
